// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : uart_pkg                                                        |
// | Purpose  : Shared state encoding and constants for the uart_fifo16 slice.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int HALF_LEVEL = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_fifo16_fifo16.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fifo16                                                          |
// | Purpose  : 16x8 first-word-fall-through FIFO with registered status flags. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fifo16 (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic [7:0] i_push_data,
  input  logic       i_pop,
  output logic [7:0] o_read_data,
  output logic       o_read_rdy,
  output logic       o_halffull
);
  import uart_pkg::*;

  logic [7:0] r_mem [FIFO_DEPTH];
  logic [3:0] r_wr_ptr;
  logic [3:0] r_rd_ptr;
  logic [4:0] r_count;
  logic [4:0] w_count_next;
  logic       r_read_rdy;
  logic       r_halffull;
  logic       w_do_push;
  logic       w_do_pop;

  // A pop on an empty FIFO is ignored, so a same-cycle push into empty wins.
  assign w_do_pop  = i_pop && r_read_rdy;
  assign w_do_push = i_push && ((r_count != 5'(FIFO_DEPTH)) || w_do_pop);

  always_comb begin
    w_count_next = r_count;
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_next = r_count + 5'd1;
      2'b01:   w_count_next = r_count - 5'd1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= 4'd0;
      r_rd_ptr   <= 4'd0;
      r_count    <= 5'd0;
      r_read_rdy <= 1'b0;
      r_halffull <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 4'd1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 4'd1;
      r_count    <= w_count_next;
      r_read_rdy <= (w_count_next != 5'd0);
      r_halffull <= (w_count_next >= 5'(HALF_LEVEL));
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_read_data = r_read_rdy ? r_mem[r_rd_ptr] : 8'd0;
  assign o_read_rdy  = r_read_rdy;
  assign o_halffull  = r_halffull;

endmodule
`default_nettype wire

// File: rtl/uart_fifo16.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_fifo16                                                     |
// | Purpose  : 8N1 UART, byte-handshake transmitter and receiver feeding a     |
// |            16-entry FWFT FIFO. Define UART_RX_MAJORITY_EN for 2-of-3 RX    |
// |            bit voting.                                                     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module uart_fifo16 #(
  parameter int unsigned CLK_DIVIDER = 1302
) (
  input  logic       clk,
  input  logic       reset,
  output logic       serial_out,
  input  logic       serial_in,
  output logic       write_rdy,
  input  logic [7:0] write_data,
  input  logic       write_strobe,
  output logic [7:0] read_data,
  output logic       read_rdy,
  input  logic       read_strobe,
  output logic       halffull
);
  import uart_pkg::*;

  localparam logic [15:0] c_DIV_LAST  = 16'(CLK_DIVIDER - 1);
  localparam logic [15:0] c_HALF_LAST = 16'(CLK_DIVIDER / 2 - 1);
  localparam logic [2:0]  c_LAST_BIT  = 3'(DATA_BITS - 1);

  uart_state_e r_tx_state;
  uart_state_e w_tx_next;
  logic [15:0] r_tx_cnt;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_shift;
  logic        w_tx_tick;
  logic        w_tx_accept;

  assign w_tx_tick   = (r_tx_cnt == c_DIV_LAST);
  assign w_tx_accept = write_strobe && (r_tx_state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_tx_state <= IDLE;
    else       r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      IDLE:    if (w_tx_accept) w_tx_next = START;
      START:   if (w_tx_tick) w_tx_next = DATA;
      DATA:    if (w_tx_tick && (r_tx_bit == c_LAST_BIT)) w_tx_next = STOP;
      STOP:    if (w_tx_tick) w_tx_next = IDLE;
      default: w_tx_next = IDLE;
    endcase
  end

  always_comb begin
    write_rdy  = (r_tx_state == IDLE);
    serial_out = 1'b1;
    case (r_tx_state)
      START:   serial_out = 1'b0;
      DATA:    serial_out = r_tx_shift[0];
      default: serial_out = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_cnt   <= 16'd0;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'd0;
    end else begin
      if ((r_tx_state == IDLE) || w_tx_tick) r_tx_cnt <= 16'd0;
      else                                   r_tx_cnt <= r_tx_cnt + 16'd1;
      if (w_tx_accept) begin
        r_tx_shift <= write_data;
        r_tx_bit   <= 3'd0;
      end else if ((r_tx_state == DATA) && w_tx_tick) begin
        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
        r_tx_bit   <= r_tx_bit + 3'd1;
      end
    end
  end

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic w_rx_bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= serial_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // r_sync1 already holds the next sample, so voting adds no latency.
`ifdef UART_RX_MAJORITY_EN
  assign w_rx_bit = maj3(r_prev, r_sync2, r_sync1);
`else
  assign w_rx_bit = r_sync2;
`endif

  uart_state_e r_rx_state;
  uart_state_e w_rx_next;
  logic [15:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;
  logic        w_rx_fall;
  logic        w_rx_half;
  logic        w_rx_tick;
  logic        w_rx_adv;
  logic        w_push;

  // Requiring a high-to-low transition also holds off re-arming after a
  // framing error until the line has returned high.
  assign w_rx_fall = r_prev && !r_sync2;
  assign w_rx_half = (r_rx_cnt == c_HALF_LAST);
  assign w_rx_tick = (r_rx_cnt == c_DIV_LAST);
  assign w_rx_adv  = ((r_rx_state == START) && w_rx_half) ||
                     (((r_rx_state == DATA) || (r_rx_state == STOP)) && w_rx_tick);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rx_state <= IDLE;
    else       r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      IDLE:    if (w_rx_fall) w_rx_next = START;
      START:   if (w_rx_half) w_rx_next = w_rx_bit ? IDLE : DATA;
      DATA:    if (w_rx_tick && (r_rx_bit == c_LAST_BIT)) w_rx_next = STOP;
      STOP:    if (w_rx_tick) w_rx_next = IDLE;
      default: w_rx_next = IDLE;
    endcase
  end

  always_comb begin
    w_push = (r_rx_state == STOP) && w_rx_tick && w_rx_bit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_cnt   <= 16'd0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'd0;
    end else begin
      if ((r_rx_state == IDLE) || w_rx_adv) r_rx_cnt <= 16'd0;
      else                                  r_rx_cnt <= r_rx_cnt + 16'd1;
      if (r_rx_state == IDLE) begin
        r_rx_bit <= 3'd0;
      end else if ((r_rx_state == DATA) && w_rx_tick) begin
        r_rx_shift <= {w_rx_bit, r_rx_shift[7:1]};
        r_rx_bit   <= r_rx_bit + 3'd1;
      end
    end
  end

  fifo16 u_fifo (
    .clk         (clk),
    .rst         (reset),
    .i_push      (w_push),
    .i_push_data (r_rx_shift),
    .i_pop       (read_strobe),
    .o_read_data (read_data),
    .o_read_rdy  (read_rdy),
    .o_halffull  (halffull)
  );

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo16.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_uart_fifo16                                                  |
// | Purpose  : Self-checking bench for uart_fifo16 against a frame-level model.|
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_uart_fifo16;
  localparam int D   = 16;
  // edge of line fall -> 2 sync flops, 1 edge detect, half bit, 9 bit periods
  localparam int LAT = 3 + D / 2 + 9 * D;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       serial_out;
  logic       serial_in;
  logic       write_rdy;
  logic [7:0] write_data = 8'd0;
  logic       write_strobe = 1'b0;
  logic [7:0] read_data;
  logic       read_rdy;
  logic       read_strobe = 1'b0;
  logic       halffull;
  logic       tb_rx = 1'b1;
  logic       loopback = 1'b0;

  assign serial_in = loopback ? serial_out : tb_rx;

  always #5 clk = ~clk;

  uart_fifo16 #(.CLK_DIVIDER(D)) dut (
    .clk          (clk),
    .reset        (reset),
    .serial_out   (serial_out),
    .serial_in    (serial_in),
    .write_rdy    (write_rdy),
    .write_data   (write_data),
    .write_strobe (write_strobe),
    .read_data    (read_data),
    .read_rdy     (read_rdy),
    .read_strobe  (read_strobe),
    .halffull     (halffull)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycle labels count posedges; queue holds FIFO contents.
  int         cyc = 0;
  logic [7:0] mq[$];
  int         pend_at[$];
  logic [7:0] pend_d[$];
  bit         tx_active = 1'b0;
  int         tx_s = 0;
  logic [7:0] tx_b = 8'd0;

  function automatic bit rdy_at(input int l);
    return !(tx_active && (l >= tx_s) && ((l - tx_s) < 10 * D));
  endfunction

  function automatic logic line_at(input int l);
    int o;
    if (rdy_at(l)) return 1'b1;
    o = (l - tx_s) / D;
    if (o == 0) return 1'b0;
    if (o == 9) return 1'b1;
    return tx_b[o - 1];
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        mq.delete();
        pend_at.delete();
        pend_d.delete();
        tx_active = 1'b0;
      end else begin
        if (read_strobe && (mq.size() > 0)) void'(mq.pop_front());
        while ((pend_at.size() > 0) && (pend_at[0] <= cyc)) begin
          if ((pend_at[0] == cyc) && (mq.size() < 16)) mq.push_back(pend_d[0]);
          void'(pend_at.pop_front());
          void'(pend_d.pop_front());
        end
        if (write_strobe && rdy_at(cyc - 1)) begin
          tx_active = 1'b1;
          tx_s      = cyc;
          tx_b      = write_data;
          if (loopback) begin
            pend_at.push_back(cyc + LAT);
            pend_d.push_back(write_data);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("read_rdy", read_rdy, (mq.size() != 0));
        check("read_data", read_data, (mq.size() != 0) ? mq[0] : 8'd0);
        check("halffull", halffull, (mq.size() >= 8));
        check("write_rdy", write_rdy, rdy_at(cyc));
        check("serial_out", serial_out, line_at(cyc));
      end
    end
  end

  task automatic send_rx(input logic [7:0] b, input logic stopb);
    logic [9:0] f;
    f = {stopb, b, 1'b0};
    @(posedge clk);
    #1;
    if (stopb) begin
      pend_at.push_back(cyc + LAT);
      pend_d.push_back(b);
    end
    for (int i = 0; i < 10; i++) begin
      tb_rx = f[i];
      repeat (D) @(posedge clk);
      #1;
    end
    tb_rx = 1'b1;
  endtask

  task automatic pop_one();
    read_strobe = 1'b1;
    @(negedge clk);
    read_strobe = 1'b0;
  endtask

  task automatic wait_tx_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!write_rdy && (n < 12 * D)) begin
      @(negedge clk);
      n++;
    end
    check("tx_idle_wait", write_rdy, 1'b1);
  endtask

  task automatic tx_byte(input logic [7:0] b);
    wait_tx_idle();
    write_data   = b;
    write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
  endtask

  logic [9:0] a5_pat = 10'b1101001010;
  logic [7:0] lb[3] = '{8'h00, 8'hFF, 8'h3C};
  logic [7:0] sent[17];
  bit         rx_done = 1'b0;
  bit         pop_on = 1'b0;

  initial begin
    int lowcnt;
    int g;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_serial_out", serial_out, 1'b1);
    check("rst_write_rdy", write_rdy, 1'b1);
    check("rst_read_rdy", read_rdy, 1'b0);
    check("rst_halffull", halffull, 1'b0);
    check("rst_read_data", read_data, 8'h00);

    // TX 0xA5 with a second strobe mid-frame
    @(posedge clk);
    #1;
    write_data   = 8'hA5;
    write_strobe = 1'b1;
    @(posedge clk);
    #1 write_strobe = 1'b0;
    lowcnt = 0;
    for (int j = 0; j < 10 * D; j++) begin
      @(negedge clk);
      if ((j % D) == D / 2) check("a5_bit", serial_out, a5_pat[j / D]);
      if (!write_rdy) lowcnt++;
      if (j == 50) begin
        write_data   = 8'h3C;
        write_strobe = 1'b1;
      end
      if (j == 51) write_strobe = 1'b0;
    end
    @(negedge clk);
    check("a5_rdy_back", write_rdy, 1'b1);
    check("a5_busy_cycles", lowcnt, 160);

    // loopback
    loopback = 1'b1;
    for (int k = 0; k < 3; k++) tx_byte(lb[k]);
    repeat (LAT + 20) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("lb_rdy", read_rdy, 1'b1);
      check("lb_data", read_data, lb[k]);
      pop_one();
    end
    check("lb_empty", read_rdy, 1'b0);
    loopback = 1'b0;

    // 17 bytes without popping
    for (int i = 0; i < 17; i++) begin
      sent[i] = 8'($urandom);
      send_rx(sent[i], 1'b1);
      check("hf_fill", halffull, ((i + 1) >= 8));
    end
    @(negedge clk);
    check("full_rdy", read_rdy, 1'b1);
    for (int i = 0; i < 16; i++) begin
      check("fifo_order", read_data, sent[i]);
      pop_one();
    end
    check("drained_rdy", read_rdy, 1'b0);
    check("drained_hf", halffull, 1'b0);

    // 4-cycle glitch, then a good frame
    @(posedge clk);
    #1 tb_rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 tb_rx = 1'b1;
    repeat (3 * D) @(negedge clk);
    check("glitch_no_push", read_rdy, 1'b0);
    send_rx(8'h5A, 1'b1);
    @(negedge clk);
    check("after_glitch_rdy", read_rdy, 1'b1);
    check("after_glitch_data", read_data, 8'h5A);
    pop_one();

    // framing error, then a good frame
    send_rx(8'h55, 1'b0);
    @(negedge clk);
    check("frame_err_no_push", read_rdy, 1'b0);
    repeat (D) @(negedge clk);
    send_rx(8'hC3, 1'b1);
    @(negedge clk);
    check("after_ferr_rdy", read_rdy, 1'b1);
    check("after_ferr_data", read_data, 8'hC3);
    pop_one();
    check("after_ferr_empty", read_rdy, 1'b0);

    // randomized concurrent traffic
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(1, 2 * D)) @(posedge clk);
          send_rx(8'($urandom), (($urandom % 8) != 0));
          if (n == 19) pop_on = 1'b1;
        end
        repeat (LAT) @(posedge clk);
        rx_done = 1'b1;
      end
      begin
        while (!rx_done) begin
          @(negedge clk);
          read_strobe = pop_on && (($urandom % 16) == 0);
        end
        read_strobe = 1'b0;
      end
      begin
        while (!rx_done) begin
          @(negedge clk);
          write_strobe = (($urandom % 32) == 0);
          write_data   = 8'($urandom);
        end
        write_strobe = 1'b0;
      end
    join
    wait_tx_idle();
    g = 0;
    while (read_rdy && (g < 20)) begin
      pop_one();
      g++;
    end
    check("rand_drain", read_rdy, 1'b0);

    // reset mid-TX with three bytes queued
    for (int k = 0; k < 3; k++) send_rx(8'(8'h10 + k), 1'b1);
    @(negedge clk);
    check("pre_rst_rdy", read_rdy, 1'b1);
    write_data   = 8'h96;
    write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
    repeat (3 * D) @(negedge clk);
    check("mid_tx_busy", write_rdy, 1'b0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("async_rst_serial_out", serial_out, 1'b1);
    check("async_rst_write_rdy", write_rdy, 1'b1);
    check("async_rst_read_rdy", read_rdy, 1'b0);
    check("async_rst_halffull", halffull, 1'b0);
    check("async_rst_read_data", read_data, 8'h00);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3 * D) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
